// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding the UART transmitter's wrsig/idle handshake.
// Optional sticky status outputs (overflow, tx_timeout) when UART_TXFIFO_STATUS_EN is defined.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int AW        = 4,
  parameter int START_TMO = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  input  logic              tx_idle,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wrsig
`ifdef UART_TXFIFO_STATUS_EN
  ,
  output logic              overflow,
  output logic              tx_timeout
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(START_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_BUSY, S_DONE} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tx_wrsig_q;
  state_e            state_q, state_d;
  logic              wr_ok;

  // Flags come from registered pointers only, so they lag the event by one cycle.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign wr_ok = wr_en && !full;

  assign wr_ptr_d = wr_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign tx_data  = tx_data_q;
  assign tx_wrsig = tx_wrsig_q;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && tx_idle) begin
          tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: state_d = S_STROBE;
      S_STROBE: begin
        tmo_d   = '0;
        state_d = S_BUSY;
      end
      // A transmitter that never goes busy loses the byte; there is no retry.
      S_BUSY: begin
        if (!tx_idle)               state_d = S_DONE;
        else if (tmo_q == TMO_LAST) state_d = S_IDLE;
        else                        tmo_d   = tmo_q + TW'(1);
      end
      S_DONE: if (tx_idle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      tmo_q      <= '0;
      tx_wrsig_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      tmo_q      <= tmo_d;
      tx_wrsig_q <= (state_d == S_STROBE);
    end
  end

`ifdef UART_TXFIFO_STATUS_EN
  logic overflow_q, tx_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      if (wr_en && full) overflow_q <= 1'b1;
      if (state_q == S_BUSY && tx_idle && tmo_q == TMO_LAST) tx_timeout_q <= 1'b1;
    end
  end

  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter driving tx_idle.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int AW = 4;

  logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, tx_idle = 1'b1;
  logic [7:0]  wr_data = 8'h00;
  logic        full, empty, tx_wrsig;
  logic [AW:0] level;
  logic [7:0]  tx_data, exp_b;
`ifdef UART_TXFIFO_STATUS_EN
  logic        overflow, tx_timeout;
`endif

  int vectors = 0, errors = 0, cyc = 0;
  int strobes = 0, last_stb = 0, prev_stb = 0, max_lvl = 0;
  int frame_len = 160, dly = 0, busy = 0;
  bit hold = 1'b0, ignore = 1'b0;
  logic [7:0] sb [$];

  uart_tx_fifo #(.DATA_W(8), .AW(AW), .START_TMO(64)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level),
    .tx_idle(tx_idle), .tx_data(tx_data), .tx_wrsig(tx_wrsig)
`ifdef UART_TXFIFO_STATUS_EN
    , .overflow(overflow), .tx_timeout(tx_timeout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transmitter model and strobe scoreboard: idle drops 2 cycles after a strobe for frame_len cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      dly = 0; busy = 0;
    end else begin
      if (tx_wrsig) begin
        strobes++; prev_stb = last_stb; last_stb = cyc;
        vectors++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL strobe_unexpected: tx_data=%h with nothing expected", tx_data);
        end else begin
          exp_b = sb.pop_front();
          if (tx_data !== exp_b) begin errors++; $display("FAIL strobe_data: got %h expected %h", tx_data, exp_b); end
        end
        if (!ignore) dly = 2;
      end
      if (busy > 0) busy--;
      if (dly > 0) begin dly--; if (dly == 0) busy = frame_len; end
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    tx_idle = !(hold || busy > 0);
  end

  task automatic wait_strobes(input int target, input int budget, input string name);
    int n = 0;
    while (strobes < target && n < budget) begin @(negedge clk); n++; end
    vectors++;
    if (strobes < target) begin errors++; $display("FAIL %s: strobes=%0d expected %0d within %0d cycles", name, strobes, target, budget); end
  endtask

  task automatic test_reset;
    vectors++; if (empty !== 1'b1)    begin errors++; $display("FAIL por_empty: got %b expected 1", empty); end
    vectors++; if (full !== 1'b0)     begin errors++; $display("FAIL por_full: got %b expected 0", full); end
    vectors++; if (level !== 5'd0)    begin errors++; $display("FAIL por_level: got %0d expected 0", level); end
    vectors++; if (tx_wrsig !== 1'b0) begin errors++; $display("FAIL por_wrsig: got %b expected 0", tx_wrsig); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL por_data: got %h expected 00", tx_data); end
    hold = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h11; @(negedge clk);
    wr_data = 8'h22; @(negedge clk);
    wr_en = 1'b0;
    vectors++; if (level !== 5'd2)    begin errors++; $display("FAIL rst_prefill_level: got %0d expected 2", level); end
    @(posedge clk); #3 rst_n = 1'b0; #1;
    vectors++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_async_empty: got %b expected 1", empty); end
    vectors++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_async_full: got %b expected 0", full); end
    vectors++; if (level !== 5'd0)    begin errors++; $display("FAIL rst_async_level: got %0d expected 0", level); end
    vectors++; if (tx_wrsig !== 1'b0) begin errors++; $display("FAIL rst_async_wrsig: got %b expected 0", tx_wrsig); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h expected 00", tx_data); end
    hold = 1'b0;
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int s0 = strobes;
    frame_len = 160; ignore = 1'b0;
    wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55);
    @(negedge clk); wr_en = 1'b0;
    vectors++; if (empty !== 1'b0)    begin errors++; $display("FAIL single_c1_empty: got %b expected 0", empty); end
    @(negedge clk);
    vectors++; if (empty !== 1'b1)    begin errors++; $display("FAIL single_c2_empty: got %b expected 1", empty); end
    vectors++; if (tx_data !== 8'h55) begin errors++; $display("FAIL single_c2_data: got %h expected 55", tx_data); end
    vectors++; if (tx_wrsig !== 1'b0) begin errors++; $display("FAIL single_c2_wrsig: got %b expected 0", tx_wrsig); end
    @(negedge clk);
    vectors++; if (tx_wrsig !== 1'b1) begin errors++; $display("FAIL single_c3_wrsig: got %b expected 1", tx_wrsig); end
    repeat (200) @(negedge clk);
    vectors++; if (strobes !== s0 + 1) begin errors++; $display("FAIL single_pulses: got %0d expected %0d", strobes - s0, 1); end
  endtask

  task automatic test_overflow;
    int s0 = strobes;
    hold = 1'b1; frame_len = 160;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      if (i < 16) sb.push_back(8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    vectors++; if (full !== 1'b1)   begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    vectors++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
`ifdef UART_TXFIFO_STATUS_EN
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
`endif
    hold = 1'b0;
    wait_strobes(s0 + 16, 16 * 200, "ovf_drain");
    repeat (200) @(negedge clk);
    vectors++; if (strobes !== s0 + 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", strobes - s0); end
    vectors++; if (sb.size() !== 0)     begin errors++; $display("FAIL ovf_leftover: got %0d expected 0", sb.size()); end
    vectors++; if (empty !== 1'b1)      begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
  endtask

  task automatic test_timeout;
    int s0 = strobes;
    ignore = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA1; sb.push_back(8'hA1); @(negedge clk);
    wr_data = 8'hA2; sb.push_back(8'hA2); @(negedge clk);
    wr_en = 1'b0;
    wait_strobes(s0 + 2, 300, "tmo_second_strobe");
    vectors++; if (last_stb - prev_stb !== 67) begin errors++; $display("FAIL tmo_gap: got %0d expected 67", last_stb - prev_stb); end
    repeat (80) @(negedge clk);
    ignore = 1'b0;
    vectors++; if (strobes !== s0 + 2) begin errors++; $display("FAIL tmo_count: got %0d expected 2", strobes - s0); end
`ifdef UART_TXFIFO_STATUS_EN
    vectors++; if (tx_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", tx_timeout); end
`endif
  endtask

  task automatic test_wrap;
    int s0 = strobes;
    frame_len = 50; ignore = 1'b0; max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i); sb.push_back(8'h30 + 8'(i));
      @(negedge clk); wr_en = 1'b0;
      repeat (99) @(negedge clk);
    end
    wait_strobes(s0 + 40, 500, "wrap_drain");
    repeat (100) @(negedge clk);
    vectors++; if (strobes !== s0 + 40) begin errors++; $display("FAIL wrap_count: got %0d expected 40", strobes - s0); end
    vectors++; if (sb.size() !== 0)     begin errors++; $display("FAIL wrap_leftover: got %0d expected 0", sb.size()); end
    vectors++; if (max_lvl > 2)         begin errors++; $display("FAIL wrap_maxlevel: got %0d expected <=2", max_lvl); end
  endtask

  task automatic test_reset_midop;
    int s0 = strobes;
    frame_len = 160;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); sb.push_back(8'hC0 + 8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (20) @(negedge clk);
    vectors++; if (level !== 5'd4) begin errors++; $display("FAIL midop_prelevel: got %0d expected 4", level); end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (level !== 5'd0)    begin errors++; $display("FAIL midop_level: got %0d expected 0", level); end
    vectors++; if (empty !== 1'b1)    begin errors++; $display("FAIL midop_empty: got %b expected 1", empty); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midop_data: got %h expected 00", tx_data); end
    sb.delete();
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    vectors++; if (strobes !== s0 + 1) begin errors++; $display("FAIL midop_strobes: got %0d expected 1", strobes - s0); end
    vectors++; if (level !== 5'd0)     begin errors++; $display("FAIL midop_post_level: got %0d expected 0", level); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    test_single;
    test_overflow;
    test_timeout;
    test_wrap;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus transmit sequencer between the UART control stage (`uartctrl`) and the UART transmitter (`uarttx`), in the 16x-baud `clk` domain.
- Accepts single-cycle write strobes from the producer without back-pressure and buffers up to DEPTH bytes.
- Replays the buffered bytes in order to the transmitter using its `wrsig`/idle handshake, so back-to-back producer bytes are never lost while a frame is in flight.

Parameters:
- DATA_W, 8, byte width.
- AW, 4, address width; DEPTH = 2**AW = 16 entries.
- START_TMO, 64, clk cycles allowed for `tx_idle` to fall after a strobe.

Ports:
- clk  in  1  16x baud clock (`clkdiv` output).
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe, one cycle per byte.
- wr_data  in  DATA_W  byte to enqueue.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  AW+1  current occupancy, 0..DEPTH.
- tx_idle  in  1  high when the transmitter is free; low while a frame is sent.
- tx_data  out  DATA_W  byte presented to the transmitter `datain`.
- tx_wrsig  out  1  one-cycle start strobe to the transmitter `wrsig`.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and level = 0; empty = 1; full = 0.
  - tx_data = 0x00; tx_wrsig = 0; FSM = S_IDLE; timeout counter = 0.
  - Reset mid-frame flushes all queued bytes; no further strobe occurs.
- Storage:
  - Read and write pointers are AW+1 bits wide and wrap modulo 2*DEPTH.
  - full = (MSBs differ, low bits equal); empty = (pointers equal); level = wr_ptr - rd_ptr.
  - All three are registered-pointer derived, so they update the cycle after the event.
- Write:
  - Accepted when wr_en && !full.
  - A write while full is silently dropped, even if a pop occurs in the same cycle.
  - Simultaneous write and pop: both take effect; level is unchanged.
- FSM:
  - S_IDLE: if !empty && tx_idle, pop: tx_data <= mem[rd_ptr], rd_ptr++, go to S_LOAD.
  - S_LOAD: hold tx_data for one setup cycle; go to S_STROBE.
  - S_STROBE: tx_wrsig = 1 for exactly this cycle; clear the timeout counter; go to S_BUSY.
  - S_BUSY: tx_idle == 0 -> S_DONE. If the counter reaches START_TMO-1 -> S_IDLE; the byte counts as consumed, with no retry.
  - S_DONE: wait for tx_idle == 1, then go to S_IDLE.
  - tx_wrsig is registered and is 0 in every state except S_STROBE.
- Latency:
  - Write into an empty FIFO at cycle 0, with tx_idle high.
  - Cycle 1: empty = 0. Cycle 2: tx_data valid, empty = 1 again. Cycle 3: tx_wrsig = 1.
- tx_data holds the last byte until the next pop.
- At most one frame is outstanding at any time.
- Bytes leave in exact write order across pointer wrap.

Optional Feature:
- Macro: UART_TXFIFO_STATUS_EN.
- Defined: adds output ports `overflow` (1) and `tx_timeout` (1), both sticky flags, reset to 0, cleared only by rst_n.
  - overflow sets on any wr_en && full.
  - tx_timeout sets when S_BUSY exits through the timeout.
- Undefined: neither port exists; dropped writes and timeouts are silent; core behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> empty=1, full=0, level=0, tx_wrsig=0, tx_data=0x00 immediately.
- Single byte: write 0x55; transmitter model drops tx_idle 2 cycles after the strobe for 160 cycles -> empty=1 at cycle 2, one tx_wrsig pulse at cycle 3 with tx_data=0x55, no second pulse.
- Overflow: hold tx_idle=0, write 0x00..0x13 on consecutive cycles -> full=1, level=16, 0x10..0x13 dropped; release tx_idle -> 16 frames 0x00..0x0F in order; with the macro, overflow=1.
- Timeout: queue 0xA1, 0xA2; tx_idle stays high after the first strobe -> return to S_IDLE after 64 cycles, 0xA2 strobed next; with the macro, tx_timeout=1.
- Wrap: stream 40 bytes 0x30..0x57, one write per 100 cycles, while the model transmits -> 40 strobes in exact order, level never exceeds 2, no drops.
- Reset mid-operation: 5 bytes queued, FSM in S_DONE, pulse rst_n -> level=0, empty=1, no further tx_wrsig after release.
